// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Port 0 (CPU) and port 1 (DMA loader) share one memory. Each access is IDLE -> ACCESS -> RESP.
// Memory strobes, acks and errors come from flops, so they never follow the request inputs combinationally.
module mem_arbiter #(
    parameter int MEM_WORDS = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] ALUOut,
    output logic [31:0] reg2data,
    input  logic [31:0] memout,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;      // 0 = port 0 owns the current access, 1 = port 1
    logic        r_last;       // port granted most recently; reset to 1 so port 0 wins first
    logic        r_we;
    logic        r_oor;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err0;
    logic        r_err1;
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    logic        w_any;
    logic        w_pick1;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_oor;

    // Winner selection: a lone requester wins; on a tie the port not granted last wins
    always_comb begin
        w_any       = req0 | req1;
        w_pick1     = req1 & (~req0 | ~r_last);
        w_sel_we    = w_pick1 ? we1    : we0;
        w_sel_addr  = w_pick1 ? addr1  : addr0;
        w_sel_wdata = w_pick1 ? wdata1 : wdata0;
        w_sel_oor   = (w_sel_addr >= MEM_LIMIT);
    end

    // Access sequencer: latch the winner, strobe memory for one cycle, then ack the owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_cnt0      <= 16'h0;
            r_cnt1      <= 16'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_pick1;
                        r_last      <= w_pick1;
                        r_we        <= w_sel_we;
                        r_oor       <= w_sel_oor;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_mem_read  <= ~w_sel_we & ~w_sel_oor;
                        r_mem_write <= w_sel_we & ~w_sel_oor;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The write commits in the external memory at this same edge
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (r_oor) begin
                        r_rdata <= 32'h0;
                    end else if (!r_we) begin
                        r_rdata <= memout;
                    end
                    r_ack0  <= ~r_owner;
                    r_ack1  <= r_owner;
                    r_err0  <= ~r_owner & r_oor;
                    r_err1  <= r_owner & r_oor;
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_err0 <= 1'b0;
                    r_err1 <= 1'b0;
                    if (r_owner) begin
                        r_cnt1 <= r_cnt1 + 16'd1;
                    end else begin
                        r_cnt0 <= r_cnt0 + 16'd1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign err0       = r_err0;
    assign err1       = r_err1;
    assign rdata      = r_rdata;
    assign MemRead    = r_mem_read;
    assign MemWrite   = r_mem_write;
    assign ALUOut     = r_addr;
    assign reg2data   = r_wdata;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It checks latency, round-robin order, the out-of-range path,
// an aborted write and grant counter wrap against a behavioural memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata;
    logic        MemRead, MemWrite;
    logic [31:0] ALUOut, reg2data;
    logic [31:0] memout;
    logic [15:0] grant_cnt0, grant_cnt1;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fails  = 0;

    mem_arbiter #(.MEM_WORDS(200)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack0       (ack0),
        .ack1       (ack1),
        .err0       (err0),
        .err1       (err1),
        .rdata      (rdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUOut     (ALUOut),
        .reg2data   (reg2data),
        .memout     (memout),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: combinational read while MemRead, write at the edge while MemWrite
    always_comb begin
        memout = 32'h0;
        if (MemRead && ALUOut < 32'd256) memout = mem[ALUOut[7:0]];
    end

    always @(posedge clk) begin
        if (MemWrite && ALUOut < 32'd256) mem[ALUOut[7:0]] = reg2data;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0;
        reset = 1'b1;
        tick();
        check("rst_ack",   {30'h0, ack1, ack0}, 32'h0);
        check("rst_strb",  {30'h0, MemWrite, MemRead}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_alu",   ALUOut, 32'h0);
        check("rst_cnt",   {grant_cnt1, grant_cnt0}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // One isolated access on one port, checking every phase of the handshake
    task automatic access(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        if (port == 0) begin
            req0 = 1; we0 = we; addr0 = addr; wdata0 = wd;
        end else begin
            req1 = 1; we1 = we; addr1 = addr; wdata1 = wd;
        end
        tick();
        req0 = 0; req1 = 0;
        check("acc_memread",  {31'h0, MemRead},  {31'h0, ~we & ~exp_err});
        check("acc_memwrite", {31'h0, MemWrite}, {31'h0, we & ~exp_err});
        check("acc_aluout",   ALUOut, addr);
        if (we) check("acc_reg2data", reg2data, wd);
        check("acc_noack",    {30'h0, ack1, ack0}, 32'h0);
        tick();
        check("rsp_ack",   {30'h0, ack1, ack0}, (port == 0) ? 32'h1 : 32'h2);
        check("rsp_err",   {30'h0, err1, err0}, exp_err ? ((port == 0) ? 32'h1 : 32'h2) : 32'h0);
        check("rsp_strb",  {30'h0, MemWrite, MemRead}, 32'h0);
        if (!we || exp_err) check("rsp_rdata", rdata, exp_rd);
        $display("txn port=%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d", port, we, addr, wd, rdata,
                 (port == 0) ? err0 : err1);
        tick();
        check("post_ack", {30'h0, ack1, ack0}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[8] = 32'hF0F0_F0F0;
        mem[5] = 32'h0000_0055;
        reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Basic read of a preloaded word from port 0
        do_reset();
        access(0, 1'b0, 32'd8, 32'h0, 32'hF0F0_F0F0, 1'b0);
        check("t1_cnt0", {16'h0, grant_cnt0}, 32'd1);

        // Write from port 1, read back from port 0
        do_reset();
        access(1, 1'b1, 32'd10, 32'h1234_5678, 32'h0, 1'b0);
        check("t2_mem10", mem[10], 32'h1234_5678);
        access(0, 1'b0, 32'd10, 32'h0, 32'h1234_5678, 1'b0);
        check("t2_cnt", {grant_cnt1, grant_cnt0}, {16'd1, 16'd1});

        // Both ports requesting continuously: grants alternate 0,1,0,1 every 3 cycles
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'd8;
        req1 = 1; we1 = 0; addr1 = 32'd9;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("rr_ack0", {31'h0, ack0}, {31'h0, (i == 2 || i == 8)});
            check("rr_ack1", {31'h0, ack1}, {31'h0, (i == 5 || i == 11)});
            check("rr_excl", {31'h0, ack0 & ack1}, 32'h0);
            if (ack0) check("rr_rdata0", rdata, 32'hF0F0_F0F0);
            if (ack1) check("rr_rdata1", rdata, 32'h1000_0009);
            $display("cycle %0d ack0=%0d ack1=%0d rdata=%h", i, ack0, ack1, rdata);
        end
        req0 = 0; req1 = 0;
        tick();
        check("rr_cnt", {grant_cnt1, grant_cnt0}, {16'd2, 16'd2});

        // Out-of-range write: no strobe, err with ack, rdata cleared, memory untouched
        do_reset();
        access(0, 1'b0, 32'd8, 32'h0, 32'hF0F0_F0F0, 1'b0);
        access(0, 1'b1, 32'd200, 32'hAAAA_5555, 32'h0, 1'b1);
        check("oor_mem200", mem[200], 32'h1000_00C8);

        // Reset in the middle of a port 1 write
        do_reset();
        req1 = 1; we1 = 1; addr1 = 32'd5; wdata1 = 32'hBAD0_BAD0;
        tick();
        req1 = 0;
        check("ab_memwrite_pre", {31'h0, MemWrite}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("ab_memwrite_rst", {31'h0, MemWrite}, 32'h0);
        check("ab_ack_rst", {30'h0, ack1, ack0}, 32'h0);
        tick();
        check("ab_noack1", {31'h0, ack1}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("ab_noack1b", {31'h0, ack1}, 32'h0);
        check("ab_mem5", mem[5], 32'h0000_0055);
        req0 = 1; we0 = 0; addr0 = 32'd8;
        req1 = 1; we1 = 0; addr1 = 32'd9;
        tick();
        req0 = 0; req1 = 0;
        tick();
        check("ab_grant", {30'h0, ack1, ack0}, 32'h1);
        check("ab_rdata", rdata, 32'hF0F0_F0F0);
        tick();

        // Grant counter wrap
        force dut.r_cnt0 = 16'hFFFF;
        #1;
        release dut.r_cnt0;
        #1;
        check("wrap_pre", {16'h0, grant_cnt0}, 32'h0000_FFFF);
        access(0, 1'b0, 32'd8, 32'h0, 32'hF0F0_F0F0, 1'b0);
        check("wrap_post", {16'h0, grant_cnt0}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 200, number of addressable data-memory words; addresses >= MEM_WORDS are out of range.
REQ-002 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Ports req0 / req1  input  1  access request from port 0 (CPU) / port 1 (DMA loader).
REQ-005 Ports we0 / we1  input  1  1 = write, 0 = read, qualified by reqN.
REQ-006 Ports addr0 / addr1  input  32  word address, qualified by reqN.
REQ-007 Ports wdata0 / wdata1  input  32  write data, qualified by reqN and weN.
REQ-008 Ports ack0 / ack1  output  1  one-cycle completion pulse to the owning port.
REQ-009 Ports err0 / err1  output  1  out-of-range flag, valid only while ackN is high.
REQ-010 Port rdata  output  32  registered read result, valid while ack0 or ack1 is high.
REQ-011 Ports MemRead / MemWrite  output  1  data-memory strobes.
REQ-012 Port ALUOut  output  32  data-memory address.
REQ-013 Port reg2data  output  32  data-memory write data.
REQ-014 Port memout  input  32  data-memory read data, combinational from ALUOut while MemRead is high.
REQ-015 Ports grant_cnt0 / grant_cnt1  output  16  completed-access count per port.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; the FSM SHALL leave reset in IDLE.
REQ-017 In IDLE, if either reqN is high at a rising edge, the block SHALL select a winner, latch its we/addr/wdata and port id, and enter ACCESS.
REQ-018 Arbitration: one requester wins alone; if both request, the port not granted last wins (round-robin); after reset port 0 has priority.
REQ-019 In ACCESS, ALUOut and reg2data SHALL carry the latched address and data, and MemRead = ~we and MemWrite = we for exactly one cycle, then the FSM enters RESP.
REQ-020 A write SHALL commit at the rising edge that ends ACCESS; for a read, rdata SHALL capture memout at that same edge.
REQ-021 For an out-of-range address, MemRead and MemWrite SHALL stay 0 in ACCESS, rdata SHALL load 0, and errN SHALL assert with ackN.
REQ-022 In RESP, ackN for the owning port SHALL be high for exactly one cycle; the FSM then returns to IDLE and grant_cntN increments, wrapping 0xFFFF -> 0x0000.
REQ-023 Latency: request sampled at edge t, ACCESS in cycle t+1, ack in cycle t+2; peak throughput is one access per 3 cycles.
REQ-024 A requester still holding reqN during its ack cycle SHALL be treated as a new request in the following IDLE cycle, subject to round-robin.
REQ-025 Request inputs SHALL be ignored outside IDLE; the non-owning port's ack and err SHALL stay 0.
REQ-026 MemRead, MemWrite, ackN and errN SHALL decode from registered state only, never combinationally from reqN.
REQ-027 ALUOut and reg2data SHALL hold their last latched values outside ACCESS.

Reset
REQ-028 When reset asserts, the block SHALL immediately force IDLE, with MemRead, MemWrite, ack0, ack1, err0 and err1 = 0.
REQ-029 While reset is high, rdata, ALUOut, reg2data and both grant_cntN SHALL be 0 and round-robin priority SHALL return to port 0.
REQ-030 Reset asserted during ACCESS SHALL deassert MemWrite before the next rising edge, so no write commits; the aborted access SHALL produce no ack.

Verification
REQ-031 Memory model preloaded word 8 = 0xF0F0F0F0; port 0 reads addr 8 -> MemRead high for 1 cycle, ack0 two cycles after request, rdata = 0xF0F0F0F0, err0 = 0.
REQ-032 Port 1 writes 0x12345678 to addr 10, then port 0 reads addr 10 -> ack1 with MemWrite pulsed once, then rdata = 0x12345678 on ack0; grant_cnt0 = grant_cnt1 = 1.
REQ-033 Both ports hold req continuously from reset for 4 accesses -> grant order 0,1,0,1, acks every 3 cycles, never both acks high.
REQ-034 Port 0 writes addr 200 -> MemWrite stays 0, ack0 = err0 = 1, rdata = 0, memory unchanged.
REQ-035 Reset pulsed mid-ACCESS of a port 1 write to addr 5 -> MemWrite drops immediately, addr 5 unchanged, no ack1, next simultaneous request granted to port 0.
REQ-036 Preload grant_cnt0 to 0xFFFF by forcing, or run 65536 accesses; one more port 0 access -> grant_cnt0 = 0x0000.
